// File: rtl/math_addsub_pipe.sv
// Pipelined adder/subtractor. The carry chain is split into SEGMENTS registered slices;
// operands are skewed into the chain and results deskewed so each sample emerges whole.
module math_addsub_pipe #(
   parameter int WIDTH       = 48,
   parameter int SEGMENTS    = 2,
   parameter int SIGNED      = 0,
   parameter int FLOP_INPUTS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             din_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] dina,
   input  logic [WIDTH-1:0] dinb,
   output logic [WIDTH:0]   dout,
   output logic             dout_valid,
   output logic             overflow
);

   localparam int SW = WIDTH / SEGMENTS;

   if ((SEGMENTS < 1) || (SEGMENTS > 8) || ((WIDTH % SEGMENTS) != 0)) begin : g_param_check
      $error("math_addsub_pipe: WIDTH must split evenly into 1..8 SEGMENTS");
   end

   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic             sub_s;
   logic             vld_s;

   if (FLOP_INPUTS != 0) begin : g_in_flop
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sub_q;
      logic             vld_q;

      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            vld_q <= 1'b0;
         end else if (ena) begin
            a_q   <= dina;
            b_q   <= dinb;
            sub_q <= sub;
            vld_q <= din_valid;
         end
      end

      assign a_s   = a_q;
      assign b_s   = b_q;
      assign sub_s = sub_q;
      assign vld_s = vld_q;
   end else begin : g_in_comb
      assign a_s   = dina;
      assign b_s   = dinb;
      assign sub_s = sub;
      assign vld_s = din_valid;
   end

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;

   assign a_ext = {(SIGNED != 0) & a_s[WIDTH-1], a_s};
   assign b_ext = {(SIGNED != 0) & b_s[WIDTH-1], b_s};

   logic vld_pipe_q [SEGMENTS];

   // NOTE: the skew/deskew arrays are cleared on reset like every other stage register,
   // so no stale slice can meet a fresh carry or leak into dout after a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SEGMENTS; i++) vld_pipe_q[i] <= 1'b0;
      end else if (ena) begin
         vld_pipe_q[0] <= vld_s;
         for (int i = 1; i < SEGMENTS; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
   end

   assign dout_valid = vld_pipe_q[SEGMENTS-1];

   // cin[k] is the carry entering stage k; it always belongs to the sample at that stage.
   logic [SEGMENTS-1:0] cin;

   for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
      localparam bit LAST = (k == SEGMENTS - 1);
      localparam int SLW  = LAST ? SW + 1 : SW;
      localparam int DSK  = SEGMENTS - 1 - k;

      logic [2*SLW:0] skew_in;
      logic [2*SLW:0] skew_tap;
      logic           sub_k;
      logic [SLW-1:0] a_k;
      logic [SLW-1:0] b_k;
      logic [SLW-1:0] b_eff;
      logic [SLW-1:0] res_d;
      logic [SLW-1:0] res_q [DSK+1];

      assign skew_in = {sub_s, a_ext[k*SW +: SLW], b_ext[k*SW +: SLW]};

      if (k == 0) begin : g_no_skew
         assign skew_tap = skew_in;
         assign cin[0]   = sub_k;
      end else begin : g_skew
         logic [2*SLW:0] skew_q [k];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int j = 0; j < k; j++) skew_q[j] <= '0;
            end else if (ena) begin
               skew_q[0] <= skew_in;
               for (int j = 1; j < k; j++) skew_q[j] <= skew_q[j-1];
            end
         end

         assign skew_tap = skew_q[k-1];
      end

      assign {sub_k, a_k, b_k} = skew_tap;
      assign b_eff             = b_k ^ {SLW{sub_k}};

      if (LAST) begin : g_top
         logic ovf_d;
         logic ovf_q;

         assign res_d = a_k + b_eff + SLW'(cin[k]);
         assign ovf_d = (SIGNED != 0) ? (res_d[SLW-1] ^ res_d[SLW-2]) : res_d[SLW-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (ena) begin
               ovf_q <= ovf_d;
            end
         end

         assign overflow = ovf_q;
      end else begin : g_mid
         logic cout_d;
         logic cout_q;

         assign {cout_d, res_d} = {1'b0, a_k} + {1'b0, b_eff} + (SLW+1)'(cin[k]);

         always_ff @(posedge clk) begin
            if (rst) begin
               cout_q <= 1'b0;
            end else if (ena) begin
               cout_q <= cout_d;
            end
         end

         assign cin[k+1] = cout_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= DSK; j++) res_q[j] <= '0;
         end else if (ena) begin
            res_q[0] <= res_d;
            for (int j = 1; j <= DSK; j++) res_q[j] <= res_q[j-1];
         end
      end

      assign dout[k*SW +: SLW] = res_q[DSK];
   end

endmodule

// File: tb/tb_math_addsub_pipe.sv
// Self-checking bench: directed 48-bit vectors on unsigned/signed builds, hand sequences
// for pulse width, stall and reset, and a behavioural model for three 36-bit builds.
module tb_math_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        din_valid;
   logic        sub;
   logic [47:0] dina;
   logic [47:0] dinb;

   logic [48:0] u_dout;
   logic        u_valid;
   logic        u_ovf;
   logic [48:0] s_dout;
   logic        s_valid;
   logic        s_ovf;
   logic [36:0] r_dout  [3];
   logic        r_valid [3];
   logic        r_ovf   [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   math_addsub_pipe #(.WIDTH(48), .SEGMENTS(3), .SIGNED(0), .FLOP_INPUTS(1)) u_u (
      .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sub(sub),
      .dina(dina), .dinb(dinb), .dout(u_dout), .dout_valid(u_valid), .overflow(u_ovf));

   math_addsub_pipe #(.WIDTH(48), .SEGMENTS(3), .SIGNED(1), .FLOP_INPUTS(1)) u_s (
      .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sub(sub),
      .dina(dina), .dinb(dinb), .dout(s_dout), .dout_valid(s_valid), .overflow(s_ovf));

   math_addsub_pipe #(.WIDTH(36), .SEGMENTS(4), .SIGNED(1), .FLOP_INPUTS(0)) u_r0 (
      .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sub(sub),
      .dina(dina[35:0]), .dinb(dinb[35:0]), .dout(r_dout[0]), .dout_valid(r_valid[0]), .overflow(r_ovf[0]));

   math_addsub_pipe #(.WIDTH(36), .SEGMENTS(4), .SIGNED(0), .FLOP_INPUTS(1)) u_r1 (
      .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sub(sub),
      .dina(dina[35:0]), .dinb(dinb[35:0]), .dout(r_dout[1]), .dout_valid(r_valid[1]), .overflow(r_ovf[1]));

   math_addsub_pipe #(.WIDTH(36), .SEGMENTS(1), .SIGNED(1), .FLOP_INPUTS(1)) u_r2 (
      .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sub(sub),
      .dina(dina[35:0]), .dinb(dinb[35:0]), .dout(r_dout[2]), .dout_valid(r_valid[2]), .overflow(r_ovf[2]));

   typedef struct {
      logic [47:0] a;
      logic [47:0] b;
      logic        sb;
      logic [48:0] ud;
      logic        uo;
      logic [48:0] sd;
      logic        so;
   } vec_t;

   typedef struct {
      logic        v;
      logic [36:0] d;
      logic        o;
   } exp_t;

   localparam int NV = 12;
   vec_t vecs [NV];
   exp_t pipe [3][8];
   int   lat  [3] = '{4, 5, 2};
   logic sgn  [3] = '{1'b1, 1'b0, 1'b1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input logic v, input logic s,
                        input logic [47:0] a, input logic [47:0] b);
      rst = r; ena = e; din_valid = v; sub = s; dina = a; dinb = b;
   endtask

   task automatic drive_vec(input int j);
      drive(1'b0, 1'b1, 1'b1, vecs[j].sb, vecs[j].a, vecs[j].b);
   endtask

   task automatic check_vec(input string tag, input int j);
      check({tag, " u_dout"},  64'(u_dout),  64'(vecs[j].ud));
      check({tag, " u_ovf"},   64'(u_ovf),   64'(vecs[j].uo));
      check({tag, " u_valid"}, 64'(u_valid), 64'd1);
      check({tag, " s_dout"},  64'(s_dout),  64'(vecs[j].sd));
      check({tag, " s_ovf"},   64'(s_ovf),   64'(vecs[j].so));
      check({tag, " s_valid"}, 64'(s_valid), 64'd1);
   endtask

   task automatic check_idle(input string tag, input logic zero_data);
      check({tag, " u_valid"}, 64'(u_valid), 64'd0);
      check({tag, " s_valid"}, 64'(s_valid), 64'd0);
      if (zero_data) begin
         check({tag, " u_dout"}, 64'(u_dout), 64'd0);
         check({tag, " u_ovf"},  64'(u_ovf),  64'd0);
         check({tag, " s_dout"}, 64'(s_dout), 64'd0);
         check({tag, " s_ovf"},  64'(s_ovf),  64'd0);
      end
   endtask

   function automatic logic [37:0] model36(input logic s, input logic [35:0] a,
                                           input logic [35:0] b, input logic sb);
      logic [36:0] ae, be, r;
      logic        o;
      ae = {s & a[35], a};
      be = {s & b[35], b};
      r  = sb ? (ae - be) : (ae + be);
      o  = s ? (r[36] ^ r[35]) : r[36];
      return {o, r};
   endfunction

   function automatic logic [35:0] pick36();
      logic [35:0] v;
      case ($urandom_range(0, 5))
         0:       v = 36'h0_0000_0000;
         1:       v = 36'hF_FFFF_FFFF;
         2:       v = 36'h8_0000_0000;
         3:       v = 36'h7_FFFF_FFFF;
         4:       v = 36'h0_0003_FFFF;
         default: v = {4'($urandom()), 32'($urandom())};
      endcase
      return v;
   endfunction

   initial begin
      logic        rr, ee, vv, ss;
      logic [47:0] aa, bb;
      int          j;

      vecs[0]  = '{48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 49'h1_0000_0000_0000, 1'b1, 49'h0_0000_0000_0000, 1'b0};
      vecs[1]  = '{48'h0000_0000_FFFF, 48'h1, 1'b0, 49'h0_0000_0001_0000, 1'b0, 49'h0_0000_0001_0000, 1'b0};
      vecs[2]  = '{48'h0000_FFFF_FFFF, 48'h1, 1'b0, 49'h0_0001_0000_0000, 1'b0, 49'h0_0001_0000_0000, 1'b0};
      vecs[3]  = '{48'h0001_0000_0000, 48'h1, 1'b1, 49'h0_0000_FFFF_FFFF, 1'b0, 49'h0_0000_FFFF_FFFF, 1'b0};
      vecs[4]  = '{48'h8000_0000_0000, 48'h1, 1'b1, 49'h0_7FFF_FFFF_FFFF, 1'b0, 49'h1_7FFF_FFFF_FFFF, 1'b1};
      vecs[5]  = '{48'h5, 48'h7, 1'b1, 49'h1_FFFF_FFFF_FFFE, 1'b1, 49'h1_FFFF_FFFF_FFFE, 1'b0};
      vecs[6]  = '{48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 49'h0_8000_0000_0000, 1'b0, 49'h0_8000_0000_0000, 1'b1};
      vecs[7]  = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 49'h1_0000_0000_0000, 1'b1, 49'h1_0000_0000_0000, 1'b1};
      vecs[8]  = '{48'h0, 48'h0, 1'b1, 49'h0, 1'b0, 49'h0, 1'b0};
      vecs[9]  = '{48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b0, 49'h0_2222_2222_2221, 1'b0, 49'h0_2222_2222_2221, 1'b0};
      vecs[10] = '{48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b1, 49'h0_0246_8ACF_1357, 1'b0, 49'h0_0246_8ACF_1357, 1'b0};
      vecs[11] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 49'h1_FFFF_FFFF_FFFE, 1'b1, 49'h1_FFFF_FFFF_FFFE, 1'b0};

      // Reset state.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 48'h0, 48'h0);
      tick();
      tick();
      check_idle("reset", 1'b1);

      // Back-to-back stream: vector i emerges after the 4th enabled edge.
      for (int i = 0; i < NV + 3; i++) begin
         if (i < NV) drive_vec(i);
         else        drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
         tick();
         if (i >= 3) begin
            j = i - 3;
            check_vec($sformatf("stream%0d", j), j);
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      check_idle("stream_tail", 1'b0);

      // Single sample: dout_valid high for exactly one cycle.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      drive_vec(0);
      for (int t = 1; t <= 6; t++) begin
         tick();
         drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
         if (t == 4) check_vec("pulse", 0);
         else        check_idle($sformatf("pulse_t%0d", t), 1'b0);
      end

      // Stall with two samples in flight behind the one at the output.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      drive_vec(0);
      tick();
      drive_vec(5);
      tick();
      drive_vec(6);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      check_vec("stall_pre", 0);
      for (int t = 0; t < 3; t++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 48'hDEAD_BEEF_CAFE, 48'h1357_9BDF_2468);
         tick();
         check_vec($sformatf("stall_hold%0d", t), 0);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      check_vec("stall_out1", 5);
      tick();
      check_vec("stall_out2", 6);
      tick();
      check_idle("stall_after1", 1'b0);
      tick();
      check_idle("stall_after2", 1'b0);

      // Reset with a full pipeline and ena low: nothing stale may emerge.
      drive_vec(7);
      tick();
      drive_vec(8);
      tick();
      drive_vec(9);
      tick();
      drive_vec(10);
      tick();
      check_vec("rst_pre", 7);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
      tick();
      check_idle("rst_now", 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      for (int t = 0; t < 6; t++) begin
         tick();
         check_idle($sformatf("rst_after%0d", t), 1'b1);
      end

      // Random traffic on the 36-bit builds against the behavioural model.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
      tick();
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 8; k++) pipe[r][k] = '{1'b0, 37'h0, 1'b0};

      for (int n = 0; n < 3000; n++) begin
         rr = ($urandom_range(0, 99) == 0);
         ee = ($urandom_range(0, 3) != 0);
         vv = ($urandom_range(0, 3) != 0);
         ss = 1'($urandom_range(0, 1));
         aa = {12'h0, pick36()};
         bb = {12'h0, pick36()};
         drive(rr, ee, vv, ss, aa, bb);
         tick();
         for (int r = 0; r < 3; r++) begin
            if (rr) begin
               for (int k = 0; k < 8; k++) pipe[r][k] = '{1'b0, 37'h0, 1'b0};
            end else if (ee) begin
               for (int k = lat[r] - 1; k > 0; k--) pipe[r][k] = pipe[r][k-1];
               {pipe[r][0].o, pipe[r][0].d} = model36(sgn[r], aa[35:0], bb[35:0], ss);
               pipe[r][0].v = vv;
            end
            check($sformatf("rand%0d_n%0d valid", r, n), 64'(r_valid[r]), 64'(pipe[r][lat[r]-1].v));
            if (pipe[r][lat[r]-1].v) begin
               check($sformatf("rand%0d_n%0d dout", r, n), 64'(r_dout[r]), 64'(pipe[r][lat[r]-1].d));
               check($sformatf("rand%0d_n%0d ovf", r, n),  64'(r_ovf[r]),  64'(pipe[r][lat[r]-1].o));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
